// File: rtl/cc_demux14_deser.sv
// Registered 1-to-N demultiplexing deserializer: steers serial bits into the lanes of a word,
// by sequential lane counter (auto) or external select (direct), with a valid/ack hand-off.
module cc_demux14_deser #(
    parameter int unsigned DEMUX_SELECTWIDTH = 2,
    parameter int unsigned DEMUX_DATAWIDTH   = 4
) (
    input  logic                         CC_DEMUX14_CLOCK_50,
    input  logic                         CC_DEMUX14_RESET_InHigh,
    input  logic                         CC_DEMUX14_data_In,
    input  logic                         CC_DEMUX14_valid_In,
    output logic                         CC_DEMUX14_ready_Out,
    input  logic                         CC_DEMUX14_mode_In,
    input  logic [DEMUX_SELECTWIDTH-1:0] CC_DEMUX14_select_InBUS,
    input  logic                         CC_DEMUX14_clear_In,
    output logic [DEMUX_DATAWIDTH-1:0]   CC_DEMUX14_z_OutBUS,
    output logic                         CC_DEMUX14_wordValid_Out,
    input  logic                         CC_DEMUX14_wordAck_In,
    output logic [DEMUX_SELECTWIDTH-1:0] CC_DEMUX14_index_OutBUS
);

    localparam logic [DEMUX_SELECTWIDTH-1:0] LastIdx = DEMUX_SELECTWIDTH'(DEMUX_DATAWIDTH - 1);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e                       state_q, state_d;
    logic [DEMUX_DATAWIDTH-1:0]   z_q, z_d;
    logic [DEMUX_DATAWIDTH-1:0]   mask_q, mask_d;
    logic [DEMUX_SELECTWIDTH-1:0] index_q, index_d;
    logic                         mode_q, mode_d;
    logic                         valid_q, valid_d;

    logic                         word_idle;
    logic                         mode_eff;
    logic                         accept;
    logic [DEMUX_DATAWIDTH-1:0]   mask_upd;

    assign CC_DEMUX14_ready_Out = (state_q == StCollect);
    assign accept               = CC_DEMUX14_valid_In & CC_DEMUX14_ready_Out;

    // Before the first bit of a word the live mode input governs; afterwards the latched copy.
    assign word_idle = (mask_q == '0) && (index_q == '0);
    assign mode_eff  = word_idle ? CC_DEMUX14_mode_In : mode_q;

    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        mask_d   = mask_q;
        index_d  = index_q;
        mode_d   = mode_q;
        valid_d  = valid_q;
        mask_upd = mask_q | (DEMUX_DATAWIDTH'(1) << CC_DEMUX14_select_InBUS);

        if (CC_DEMUX14_clear_In) begin
            state_d = StCollect;
            z_d     = '0;
            mask_d  = '0;
            index_d = '0;
            mode_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            if (word_idle) begin
                mode_d = CC_DEMUX14_mode_In;
            end
            unique case (state_q)
                StCollect: begin
                    valid_d = 1'b0;
                    if (accept) begin
                        if (!mode_eff) begin
                            z_d[index_q] = CC_DEMUX14_data_In;
                            if (index_q == LastIdx) begin
                                index_d = '0;
                                state_d = StHold;
                                valid_d = 1'b1;
                            end else begin
                                index_d = index_q + 1'b1;
                            end
                        end else begin
                            z_d[CC_DEMUX14_select_InBUS] = CC_DEMUX14_data_In;
                            if (&mask_upd) begin
                                mask_d  = '0;
                                state_d = StHold;
                                valid_d = 1'b1;
                            end else begin
                                mask_d = mask_upd;
                            end
                        end
                    end
                end
                StHold: begin
                    valid_d = 1'b1;
                    if (CC_DEMUX14_wordAck_In) begin
                        state_d = StCollect;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StCollect;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CC_DEMUX14_CLOCK_50) begin
        if (CC_DEMUX14_RESET_InHigh) begin
            state_q <= StCollect;
            z_q     <= '0;
            mask_q  <= '0;
            index_q <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            mask_q  <= mask_d;
            index_q <= index_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    assign CC_DEMUX14_z_OutBUS      = z_q;
    assign CC_DEMUX14_wordValid_Out = valid_q;
    assign CC_DEMUX14_index_OutBUS  = index_q;

endmodule

// File: tb/tb_cc_demux14_deser.sv
// Directed self-checking bench for cc_demux14_deser with hand-computed expectations.
module tb_cc_demux14_deser;

    logic       clk;
    logic       rst;
    logic       data_in;
    logic       valid_in;
    logic       ready;
    logic       mode_in;
    logic [1:0] sel;
    logic       clear_in;
    logic [3:0] z;
    logic       word_valid;
    logic       ack;
    logic [1:0] index;

    int n_cmp;
    int n_err;

    cc_demux14_deser #(
        .DEMUX_SELECTWIDTH(2),
        .DEMUX_DATAWIDTH  (4)
    ) dut (
        .CC_DEMUX14_CLOCK_50     (clk),
        .CC_DEMUX14_RESET_InHigh (rst),
        .CC_DEMUX14_data_In      (data_in),
        .CC_DEMUX14_valid_In     (valid_in),
        .CC_DEMUX14_ready_Out    (ready),
        .CC_DEMUX14_mode_In      (mode_in),
        .CC_DEMUX14_select_InBUS (sel),
        .CC_DEMUX14_clear_In     (clear_in),
        .CC_DEMUX14_z_OutBUS     (z),
        .CC_DEMUX14_wordValid_Out(word_valid),
        .CC_DEMUX14_wordAck_In   (ack),
        .CC_DEMUX14_index_OutBUS (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_auto(input logic b);
        valid_in = 1'b1;
        data_in  = b;
        step();
        valid_in = 1'b0;
    endtask

    task automatic send_direct(input logic [1:0] lane, input logic b);
        valid_in = 1'b1;
        sel      = lane;
        data_in  = b;
        step();
        valid_in = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        data_in  = 1'b0;
        valid_in = 1'b0;
        mode_in  = 1'b0;
        sel      = 2'd0;
        clear_in = 1'b0;
        ack      = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_z", 32'(z), 32'h0);
        check_eq("rst_valid", 32'(word_valid), 32'h0);
        check_eq("rst_ready", 32'(ready), 32'h1);
        check_eq("rst_index", 32'(index), 32'h0);

        // 1: auto word 1,0,1,1 into lanes 0..3
        send_auto(1'b1);
        check_eq("t1_index1", 32'(index), 32'h1);
        send_auto(1'b0);
        send_auto(1'b1);
        check_eq("t1_valid_early", 32'(word_valid), 32'h0);
        send_auto(1'b1);
        check_eq("t1_valid", 32'(word_valid), 32'h1);
        check_eq("t1_z", 32'(z), 32'hD);
        check_eq("t1_ready", 32'(ready), 32'h0);
        check_eq("t1_index", 32'(index), 32'h0);

        // 2: bits offered in HOLD are dropped; ack releases the word
        valid_in = 1'b1;
        data_in  = 1'b0;
        for (int i = 0; i < 3; i++) step();
        valid_in = 1'b0;
        check_eq("t2_z_hold", 32'(z), 32'hD);
        check_eq("t2_valid_hold", 32'(word_valid), 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_eq("t2_valid_ack", 32'(word_valid), 32'h0);
        check_eq("t2_ready_ack", 32'(ready), 32'h1);
        check_eq("t2_z_after_ack", 32'(z), 32'hD);

        // 3: direct mode with overwrite of lane 2
        mode_in = 1'b1;
        send_direct(2'd2, 1'b1);
        send_direct(2'd0, 1'b0);
        send_direct(2'd2, 1'b0);
        send_direct(2'd3, 1'b1);
        check_eq("t3_valid_early", 32'(word_valid), 32'h0);
        check_eq("t3_index", 32'(index), 32'h0);
        send_direct(2'd1, 1'b1);
        check_eq("t3_valid", 32'(word_valid), 32'h1);
        check_eq("t3_z", 32'(z), 32'hA);
        mode_in = 1'b0;
        ack     = 1'b1;
        step();
        ack = 1'b0;

        // 4: mode change mid-word is ignored
        send_auto(1'b1);
        send_auto(1'b1);
        mode_in = 1'b1;
        sel     = 2'd3;
        send_auto(1'b0);
        check_eq("t4_index", 32'(index), 32'h3);
        check_eq("t4_valid_early", 32'(word_valid), 32'h0);
        send_auto(1'b1);
        check_eq("t4_valid", 32'(word_valid), 32'h1);
        check_eq("t4_z", 32'(z), 32'hB);
        mode_in = 1'b0;
        ack     = 1'b1;
        step();
        ack = 1'b0;

        // 5: clear with valid drops the bit and resets the word
        send_auto(1'b1);
        send_auto(1'b1);
        send_auto(1'b1);
        check_eq("t5_index3", 32'(index), 32'h3);
        clear_in = 1'b1;
        valid_in = 1'b1;
        data_in  = 1'b1;
        step();
        clear_in = 1'b0;
        valid_in = 1'b0;
        check_eq("t5_z_clr", 32'(z), 32'h0);
        check_eq("t5_index_clr", 32'(index), 32'h0);
        check_eq("t5_valid_clr", 32'(word_valid), 32'h0);
        check_eq("t5_ready_clr", 32'(ready), 32'h1);
        send_auto(1'b0);
        send_auto(1'b1);
        send_auto(1'b0);
        send_auto(1'b0);
        check_eq("t5_valid", 32'(word_valid), 32'h1);
        check_eq("t5_z", 32'(z), 32'h2);

        // 6: synchronous reset in HOLD acts only at the edge
        rst = 1'b1;
        #3;
        check_eq("t6_valid_midcycle", 32'(word_valid), 32'h1);
        check_eq("t6_z_midcycle", 32'(z), 32'h2);
        step();
        rst = 1'b0;
        check_eq("t6_valid", 32'(word_valid), 32'h0);
        check_eq("t6_ready", 32'(ready), 32'h1);
        check_eq("t6_z", 32'(z), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cc_demux14_deser.md
Name: cc_demux14_deser

Overview:
Registered 1-to-N demultiplexing deserializer. It is the write-side counterpart of the team's N:1 lane-select multiplexer. It steers a serial bit stream into the lanes of a DATAWIDTH-bit word, using either an internal sequential lane counter or an external lane select. The completed word is presented with a valid/ack handshake. It sits between serial sources (button/LFSR streams, UART bit logic) and the game's parallel registers (LED matrix row data, car/road lane flags).

Parameters:
DEMUX_SELECTWIDTH, 2, width of lane index/select
DEMUX_DATAWIDTH, 4, lanes per word; must equal 2**DEMUX_SELECTWIDTH

Ports:
CC_DEMUX14_CLOCK_50  input  1  system clock; all logic on rising edge
CC_DEMUX14_RESET_InHigh  input  1  synchronous, active-high reset
CC_DEMUX14_data_In  input  1  serial data bit
CC_DEMUX14_valid_In  input  1  data_In qualifies this cycle
CC_DEMUX14_ready_Out  output  1  block accepts a bit this cycle
CC_DEMUX14_mode_In  input  1  0 = auto sequential lanes, 1 = direct addressed lanes
CC_DEMUX14_select_InBUS  input  DEMUX_SELECTWIDTH  target lane in direct mode; ignored in auto mode
CC_DEMUX14_clear_In  input  1  synchronous abort/clear of the current word
CC_DEMUX14_z_OutBUS  output  DEMUX_DATAWIDTH  assembled word
CC_DEMUX14_wordValid_Out  output  1  z_OutBUS complete and stable
CC_DEMUX14_wordAck_In  input  1  consumer has taken the word
CC_DEMUX14_index_OutBUS  output  DEMUX_SELECTWIDTH  next lane in auto mode (debug/status)

Behaviour:
- Accept = valid_In & ready_Out, sampled at the rising edge. Bits presented while ready_Out=0 are dropped; upstream must honour ready.
- Reset (highest priority) and clear_In (second priority) have identical effect on the next edge:
  - state=COLLECT, z_OutBUS=0, wordValid_Out=0, index=0, lane mask=0, latched mode=0.
  - ready_Out=1 on the following cycle.
- State COLLECT:
  - ready_Out=1, wordValid_Out=0.
  - Latched mode loads mode_In on every edge while mask==0 and index==0. It is frozen once the first bit of a word is accepted, so mode changes mid-word have no effect until the next word.
  - Auto mode, on accept: z[index]<=data_In; index<=index+1. If index==DATAWIDTH-1, then index<=0 and state<=HOLD.
  - Direct mode, on accept: z[select_InBUS]<=data_In; mask[select]<=1. A repeat write to an already-filled lane overwrites the bit; mask is unchanged. When the updated mask becomes all ones, mask<=0 and state<=HOLD.
  - Lanes not yet written this word keep their previous-word values. z_OutBUS is only meaningful while wordValid_Out=1.
  - wordAck_In is ignored.
- State HOLD:
  - ready_Out=0, wordValid_Out=1, z_OutBUS frozen.
  - On wordAck_In=1: state<=COLLECT; wordValid_Out=0 and ready_Out=1 from the next cycle.
  - Ack without a subsequent bit leaves z_OutBUS holding its value.
- Latency: wordValid_Out rises the cycle after the edge that accepted the last lane. Minimum word period is DATAWIDTH accept cycles + 1 HOLD cycle (ack held high continuously).
- index_OutBUS reflects the internal index register. It is 0 in direct mode.
- Clear or reset during HOLD discards the word with no ack required.
- Clear asserted together with valid_In: the clear wins and the bit is dropped.
- All outputs are registered except ready_Out, which is decoded from state.

Test Plan:
1. Reset, auto mode, send bits 1,0,1,1 on 4 consecutive cycles -> wordValid=1 on cycle 5, z_OutBUS=4'b1101, ready=0, index=0.
2. In HOLD, drive valid with data=0 for 3 cycles, no ack -> z stays 4'b1101, wordValid stays 1. Ack for one cycle -> wordValid=0, ready=1 next cycle.
3. Direct mode, write lane2=1, lane0=0, lane2=0 (overwrite), lane3=1, lane1=1 -> wordValid rises only after lane1, z=4'b1010.
4. Auto mode, accept 2 bits, then toggle mode_In=1 with select=3 -> remaining 2 bits still land in lanes 2,3 sequentially, and the word completes after 4 accepts.
5. After 3 accepted bits assert clear_In together with valid_In -> next cycle z=0, index=0, wordValid=0. A fresh 4-bit word then completes normally.
6. Assert RESET_InHigh for one cycle while in HOLD -> wordValid=0, ready=1, z=0 on the next cycle. Verify the synchronous reset does not act between clock edges.
